// File: rtl/ram_sync_fill_if.sv
// Bus bundle for ram_sync_fill: write port, read port and fill-engine control/status.
// The master drives requests; the slave (the RAM) returns read data and status strobes.
interface ram_sync_fill_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              init_req;
    logic              busy;
    logic              drop;

    modport master (
        output we, waddr, wdata, re, raddr, init_req,
        input  rdata, rvalid, busy, drop
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, init_req,
        output rdata, rvalid, busy, drop
    );
endinterface

// File: rtl/ram_sync_fill.sv
// Synchronous single-clock RAM with registered read port and a sequential fill engine.
// Reset zeroes all words; the fill sweep writes FILL_VALUE to every address.
module ram_sync_fill #(
    parameter int                 DATA_W     = 8,
    parameter int                 ADDR_W     = 3,
    parameter logic [DATA_W-1:0]  FILL_VALUE = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  clear,
    ram_sync_fill_if.slave        bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              drop;

    // Accesses are only serviced in IDLE; during FILL they are rejected and flagged via drop.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            ptr    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            drop   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rvalid <= 1'b0;
            drop   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.re) begin
                        rdata  <= mem[bus.raddr];
                        rvalid <= 1'b1;
                    end
                    if (bus.we) begin
                        mem[bus.waddr] <= bus.wdata;
                    end
                    if (bus.init_req) begin
                        state <= FILL;
                        ptr   <= '0;
                    end
                end
                FILL: begin
                    mem[ptr] <= FILL_VALUE;
                    ptr      <= ptr + 1'b1;
                    drop     <= bus.we | bus.re;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata  = rdata;
    assign bus.rvalid = rvalid;
    assign bus.drop   = drop;
    assign bus.busy   = (state == FILL);
endmodule

// File: tb/tb_ram_sync_fill.sv
// Directed self-checking bench for ram_sync_fill (8 words x 8 bits, FILL_VALUE = 0xC3).
module tb_ram_sync_fill;
    logic clk;
    logic clear;
    int   checks;
    int   errors;

    ram_sync_fill_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    ram_sync_fill #(
        .DATA_W(8),
        .ADDR_W(3),
        .FILL_VALUE(8'hC3)
    ) dut (
        .clk(clk),
        .clear(clear),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return #1 after the next rising edge.
    task automatic applyStimulus(input logic we, input logic [2:0] waddr, input logic [7:0] wdata,
                                 input logic re, input logic [2:0] raddr, input logic init);
        @(negedge clk);
        bus.we       = we;
        bus.waddr    = waddr;
        bus.wdata    = wdata;
        bus.re       = re;
        bus.raddr    = raddr;
        bus.init_req = init;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic doWrite(input logic [2:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic doRead(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, addr, 1'b0);
        checkOutput({tag, "_rdata"}, 32'(bus.rdata), 32'(exp));
        checkOutput({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            idleCycle();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int busyCount;
        checks       = 0;
        errors       = 0;
        clear        = 1'b1;
        bus.we       = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.re       = 1'b0;
        bus.raddr    = '0;
        bus.init_req = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rdata", 32'(bus.rdata), 32'h0);
        checkOutput("rst_rvalid", 32'(bus.rvalid), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_drop", 32'(bus.drop), 32'h0);
        @(negedge clk);
        clear = 1'b0;

        doRead("rst_read5", 3'd5, 8'h00);
        for (int i = 0; i < 8; i++) doRead("rst_readall", 3'(i), 8'h00);

        doWrite(3'd0, 8'hAA);
        doWrite(3'd1, 8'h55);
        doRead("rb_addr0", 3'd0, 8'hAA);
        doRead("rb_addr1", 3'd1, 8'h55);
        idleCycle();
        checkOutput("rb_hold_rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("rb_hold_rdata", 32'(bus.rdata), 32'h55);

        doWrite(3'd2, 8'h11);
        applyStimulus(1'b1, 3'd2, 8'hFF, 1'b1, 3'd2, 1'b0);
        checkOutput("coll_old", 32'(bus.rdata), 32'h11);
        doRead("coll_new", 3'd2, 8'hFF);

        for (int i = 0; i < 8; i++) doWrite(3'(i), 8'hAA);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
        checkOutput("fill_busy_start", 32'(bus.busy), 32'd1);
        busyCount = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) applyStimulus(1'b1, 3'd3, 8'h00, 1'b1, 3'd3, 1'b0);
            else if (i == 4) applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
            else idleCycle();
            if (i == 2) begin
                checkOutput("fill_drop", 32'(bus.drop), 32'd1);
                checkOutput("fill_rej_rvalid", 32'(bus.rvalid), 32'd0);
            end
            if (i == 3) checkOutput("fill_drop_clr", 32'(bus.drop), 32'd0);
            if (!bus.busy) break;
            busyCount++;
        end
        checkOutput("fill_busy_len", 32'(busyCount), 32'd8);
        for (int i = 0; i < 8; i++) doRead("fill_readall", 3'(i), 8'hC3);

        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
        #2;
        clear = 1'b1;
        #1;
        checkOutput("abort_busy_async", 32'(bus.busy), 32'd0);
        checkOutput("abort_rdata", 32'(bus.rdata), 32'h0);
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 8; i++) doRead("abort_readall", 3'(i), 8'h00);

        doWrite(3'd1, 8'h55);
        applyStimulus(1'b1, 3'd4, 8'h77, 1'b1, 3'd1, 1'b1);
        checkOutput("same_rdata", 32'(bus.rdata), 32'h55);
        checkOutput("same_rvalid", 32'(bus.rvalid), 32'd1);
        checkOutput("same_busy", 32'(bus.busy), 32'd1);
        waitIdle("same");
        doRead("same_addr4", 3'd4, 8'hC3);
        doRead("same_addr1", 3'd1, 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_sync_fill.md
Name: ram_sync_fill

Overview:
- Parametrised synchronous single-clock RAM, DEPTH = 2**ADDR_W words of DATA_W bits.
- Separate write and read ports, both usable in the same cycle.
- Read data is registered, with a valid strobe.
- Built-in sequential fill engine sweeps every address with FILL_VALUE on request.
- Successor to the fixed 8x8 bit-wise RAM; serves as a generic storage block for register-file and buffer users in the datapath.

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W (>=1)
FILL_VALUE, {DATA_W{1'b0}}, word written to every address by the fill engine

Ports:
clk  input  1  clock, all state updates on rising edge
clear  input  1  asynchronous active-high reset
we  input  1  write request
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
re  input  1  read request
raddr  input  ADDR_W  read address
rdata  output  DATA_W  registered read data
rvalid  output  1  one-cycle strobe: rdata updated this cycle
init_req  input  1  start fill sweep (sampled only when idle)
busy  output  1  fill engine active
drop  output  1  one-cycle strobe: a we or re was rejected because busy

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk; reset port is clear.
- Reset (clear=1, asynchronous):
  - All DEPTH words become 0.
  - rdata=0, rvalid=0, busy=0, drop=0.
  - FSM goes to IDLE; fill pointer is 0.
  - Holds for as long as clear is high; normal operation resumes on the first rising edge after clear falls.
- Clear mid-fill aborts the sweep immediately. The result is all-zero memory, not FILL_VALUE.
- FSM has 2 states:
  - IDLE -> FILL on an edge with init_req=1; ptr<=0.
  - FILL: each edge writes mem[ptr]<=FILL_VALUE and increments ptr. On the edge with ptr==DEPTH-1, the last word is written and the FSM returns to IDLE.
  - busy = (state==FILL), decoded from state with no extra register delay.
  - busy is high for exactly DEPTH cycles, starting the cycle after the request edge.
- init_req while busy is ignored; there is no queued restart.
- Write in IDLE: on an edge with we=1, mem[waddr]<=wdata. Latency 0; the word is visible to a read issued on the next edge.
- Read in IDLE: on an edge with re=1, rdata<=mem[raddr] and rvalid<=1.
  - Otherwise rvalid<=0 and rdata holds its last value; it is not zeroed between reads.
  - Read latency is 1 cycle.
- Read/write same address, same edge: read-first. rdata gets the old word; the new word is stored.
- Same-edge init_req and we/re in IDLE: the write and read are performed normally, then the fill starts. The written word is later overwritten by FILL_VALUE.
- we or re on an edge while busy:
  - The access is not performed; rvalid stays 0 and memory is unchanged.
  - drop<=1 for one cycle. drop<=0 on any edge without a rejection.
- Addresses always index in range (2**ADDR_W words), so there is no out-of-range case.
- The fill pointer is ADDR_W wide. Termination is by the ptr==DEPTH-1 compare, not by wrap.

Test Plan:
- Reset then read: clear pulse, re=1 raddr=5 -> next cycle rdata=0x00, rvalid=1; all 8 addresses read 0x00.
- Write/read back: we addr0=0xAA, addr1=0x55; then re addr0, addr1 -> rdata 0xAA then 0x55, each with rvalid=1 one cycle after re. rvalid=0 and rdata holds 0x55 when re=0.
- Collision: mem[2]=0x11; same edge we addr2=0xFF and re addr2 -> rdata=0x11; a following read of addr2 returns 0xFF.
- Fill (FILL_VALUE=0xC3): preload all words 0xAA, pulse init_req -> busy high exactly 8 cycles. A we=1 addr3=0x00 issued mid-fill gives drop=1 for one cycle and no change. After busy falls, all 8 words read 0xC3. An init_req while busy does not extend busy.
- Clear mid-fill: start fill, assert clear after 3 busy cycles -> busy=0 immediately (asynchronous), and all words read 0x00 afterwards.
- Same-edge init_req + re addr1 (mem[1]=0x55): rdata=0x55, rvalid=1 on the next cycle, busy=1 on the next cycle.
